// File: rtl/k_and_s_pkg.sv
//------------------------------------------------------------------------------
// k_and_s_pkg : shared constants and types for the K-and-S memory subsystem
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package k_and_s_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } mem_owner_t;

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
//------------------------------------------------------------------------------
// ram_port_arbiter : shares the single-port RAM between the core and debug master
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt;
    mem_owner_t        owner;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic              core_wins;
    logic              dbg_wins;

    // Debug wins outright when locked or starved; otherwise the core has priority.
    always_comb begin
        core_wins = 1'b0;
        dbg_wins  = 1'b0;
        if (rst_n) begin
            if (dbg_req && (dbg_lock || wait_cnt == MAX_WAIT_C))
                dbg_wins = 1'b1;
            else if (core_req && !dbg_lock)
                core_wins = 1'b1;
            else if (dbg_req)
                dbg_wins = 1'b1;
        end
    end

    always_comb begin
        ram_addr  = hold_addr;
        ram_wdata = hold_wdata;
        ram_we    = 1'b0;
        if (core_wins) begin
            ram_addr  = core_addr;
            ram_wdata = core_wdata;
            ram_we    = core_we;
        end else if (dbg_wins) begin
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            ram_we    = dbg_we;
        end
    end

    assign core_gnt = core_wins;
    assign dbg_gnt  = dbg_wins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= 4'd0;
            owner      <= OWN_NONE;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            hold_addr  <= ram_addr;
            hold_wdata <= ram_wdata;

            if (dbg_wins)
                wait_cnt <= 4'd0;
            else if (dbg_req && wait_cnt != MAX_WAIT_C)
                wait_cnt <= wait_cnt + 4'd1;

            if (core_wins && !core_we)
                owner <= OWN_CORE;
            else if (dbg_wins && !dbg_we)
                owner <= OWN_DBG;
            else
                owner <= OWN_NONE;
        end
    end

    // Read data is broadcast; rvalid alone tells each master the word is its own.
    assign core_rvalid = (owner == OWN_CORE);
    assign dbg_rvalid  = (owner == OWN_DBG);
    assign core_rdata  = ram_rdata;
    assign dbg_rdata   = ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_ram_port_arbiter : scoreboard bench for ram_port_arbiter with a RAM model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;
    import k_and_s_pkg::*;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              core_req = 0, core_we = 0;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [DATA_W-1:0] core_wdata = '0;
    logic              core_gnt, core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              dbg_req = 0, dbg_we = 0, dbg_lock = 0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic              dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata = '0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM, one cycle read latency.
    logic [DATA_W-1:0] ram [32];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram_we ? ram_wdata : ram[ram_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    typedef struct {
        mem_owner_t        own;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] gmem [32];
    int                m_wait = 0;

    // Reference model: evaluated mid-cycle when inputs are stable.
    always @(negedge clk) begin
        logic e_core, e_dbg;
        exp_t e;
        if (!rst_n) begin
            check("rst_core_gnt", core_gnt, 0);
            check("rst_dbg_gnt", dbg_gnt, 0);
            check("rst_core_rvalid", core_rvalid, 0);
            check("rst_dbg_rvalid", dbg_rvalid, 0);
            check("rst_ram_we", ram_we, 0);
            m_wait = 0;
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("core_rvalid", core_rvalid, e.own == OWN_CORE);
                check("dbg_rvalid", dbg_rvalid, e.own == OWN_DBG);
                if (e.own == OWN_CORE) check("core_rdata", core_rdata, e.data);
                else                   check("dbg_rdata", dbg_rdata, e.data);
            end else begin
                check("idle_core_rvalid", core_rvalid, 0);
                check("idle_dbg_rvalid", dbg_rvalid, 0);
            end

            e_core = core_req && !dbg_lock && !(dbg_req && m_wait == MAX_WAIT);
            e_dbg  = dbg_req && !e_core;
            check("core_gnt", core_gnt, e_core);
            check("dbg_gnt", dbg_gnt, e_dbg);
            check("ram_we", ram_we, (e_core && core_we) || (e_dbg && dbg_we));

            if (e_core || e_dbg) begin
                logic              we;
                logic [ADDR_W-1:0] a;
                logic [DATA_W-1:0] wd;
                we = e_core ? core_we : dbg_we;
                a  = e_core ? core_addr : dbg_addr;
                wd = e_core ? core_wdata : dbg_wdata;
                check("ram_addr", ram_addr, a);
                if (we) begin
                    check("ram_wdata", ram_wdata, wd);
                    gmem[a] = wd;
                end else begin
                    e.own  = e_core ? OWN_CORE : OWN_DBG;
                    e.data = gmem[a];
                    exp_q.push_back(e);
                end
            end

            if (e_dbg)                               m_wait = 0;
            else if (dbg_req && m_wait < MAX_WAIT)   m_wait = m_wait + 1;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic core_acc(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit got = 0;
        core_req = 1; core_we = we; core_addr = a; core_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = core_gnt;
            cyc();
        end
        check("core_acc_granted", got, 1);
        core_req = 0;
    endtask

    task automatic dbg_acc(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit got = 0;
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = dbg_gnt;
            cyc();
        end
        check("dbg_acc_granted", got, 1);
        dbg_req = 0;
    endtask

    initial begin
        int core_wins;
        bit seen_dbg;

        for (int i = 0; i < 32; i++) begin
            ram[i]  = 16'(i * 16'h0101 + 16'h0F00);
            gmem[i] = 16'(i * 16'h0101 + 16'h0F00);
        end
        ram[3]  = 16'hA5A5;
        gmem[3] = 16'hA5A5;

        repeat (3) cyc();
        rst_n = 1;
        cyc();

        // Core-only read of address 3.
        core_acc(0, 5'd3, '0);
        @(negedge clk);
        check("a5a5_rvalid", core_rvalid, 1);
        check("a5a5_rdata", core_rdata, 16'hA5A5);
        cyc();

        // Both held: four core wins before the forced debug win.
        core_req = 1; core_we = 0; core_addr = 5'd4;
        dbg_req  = 1; dbg_we  = 0; dbg_addr  = 5'd5;
        core_wins = 0; seen_dbg = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dbg_gnt) seen_dbg = 1;
            else if (!seen_dbg && core_gnt) core_wins++;
            cyc();
        end
        check("starve_core_wins", core_wins, MAX_WAIT);
        check("starve_dbg_seen", seen_dbg, 1);
        core_req = 0; dbg_req = 0;
        repeat (2) cyc();

        // Loader lock: debug writes while the core is held off.
        core_req = 1; core_we = 0; core_addr = 5'd7;
        dbg_lock = 1;
        dbg_acc(1, 5'd7, 16'h1234);
        repeat (2) begin
            @(negedge clk);
            check("lock_core_gnt", core_gnt, 0);
            cyc();
        end
        dbg_lock = 0;
        core_acc(0, 5'd7, '0);
        @(negedge clk);
        check("lock_readback", core_rdata, 16'h1234);
        cyc();

        // Alternating masters on consecutive cycles.
        core_req = 1; core_we = 0; core_addr = 5'd1;
        cyc();
        core_req = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 5'd2;
        cyc();
        dbg_req = 0;
        repeat (2) cyc();

        // Lock rises while a core read is in flight.
        core_req = 1; core_we = 0; core_addr = 5'd9;
        cyc();
        core_req = 0; dbg_lock = 1;
        @(negedge clk);
        check("inflight_rvalid", core_rvalid, 1);
        cyc();
        dbg_lock = 0;

        // Write then read same address back to back.
        core_req = 1; core_we = 1; core_addr = 5'd10; core_wdata = 16'hBEEF;
        cyc();
        core_we = 0;
        cyc();
        core_req = 0;
        @(negedge clk);
        check("wr_rd_data", core_rdata, 16'hBEEF);
        cyc();

        // Reset the cycle after a core read grant, with debug accruing wait.
        core_req = 1; core_we = 0; core_addr = 5'd6;
        dbg_req = 1; dbg_we = 0; dbg_addr = 5'd8;
        cyc();
        core_req = 0; dbg_req = 0;
        rst_n = 0;
        repeat (2) cyc();
        rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_core_rvalid", core_rvalid, 0);
            cyc();
        end
        core_req = 1; dbg_req = 1;
        repeat (7) cyc();
        core_req = 0; dbg_req = 0;
        cyc();

        // Random traffic under the reference model.
        for (int i = 0; i < 300; i++) begin
            core_req   = 1'($urandom_range(0, 1));
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = 5'($urandom);
            core_wdata = 16'($urandom);
            dbg_req    = 1'($urandom_range(0, 1));
            dbg_we     = 1'($urandom_range(0, 1));
            dbg_addr   = 5'($urandom);
            dbg_wdata  = 16'($urandom);
            dbg_lock   = ($urandom_range(0, 7) == 0);
            cyc();
        end
        core_req = 0; dbg_req = 0; dbg_lock = 0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
